// File: rtl/chrom_serial_loader.sv
`default_nettype none
// ============================================================================
// Module  : chrom_serial_loader
// Brief   : Assembles a chromosome from a valid/ready byte stream in a shadow
//           register and commits it atomically to the evaluator.
// Rev     : 1.0
// ============================================================================
module chrom_serial_loader #(
  parameter int ROW       = 1,
  parameter int COL       = 3,
  parameter int OUT       = 2,
  parameter int BITS_ELEM = 1,
  parameter int BITS_MAT  = ROW * COL * 16,
  parameter int CHROM_W   = BITS_MAT + BITS_ELEM * OUT,
  parameter int NBYTES    = (CHROM_W + 7) / 8,
  parameter logic [CHROM_W-1:0] INIT_CHROM = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load_start,
  input  logic [7:0]                       s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic [CHROM_W-1:0]               chrom_out,
  output logic                             chrom_valid,
  output logic                             chrom_update,
  output logic                             busy,
  output logic [$clog2(NBYTES+1)-1:0]      byte_cnt
);

  localparam int CNT_W = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] c_last_byte = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECV   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CHROM_W-1:0] r_shadow;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic [CHROM_W-1:0] r_chrom;
  logic               r_chrom_valid;
  logic               r_chrom_update;
  logic               w_accept;

  // A restart request takes priority over a byte offered in the same cycle.
  assign s_ready  = (r_state == S_RECV) && !load_start;
  assign w_accept = s_valid && s_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (load_start) w_state_next = S_RECV;
      end
      S_RECV: begin
        if (load_start)                                w_state_next = S_RECV;
        else if (w_accept && r_byte_cnt == c_last_byte) w_state_next = S_COMMIT;
      end
      S_COMMIT: begin
        w_state_next = load_start ? S_RECV : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst)                          r_byte_cnt <= '0;
    else if (load_start)              r_byte_cnt <= '0;
    else if (w_accept)                r_byte_cnt <= r_byte_cnt + 1'b1;
    else if (w_state_next == S_IDLE)  r_byte_cnt <= '0;
  end

  // Bit-wise write lets the unused top bits of the final byte fall away.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (w_accept) begin
      for (int b = 0; b < CHROM_W; b++) begin
        if (r_byte_cnt == CNT_W'(b / 8)) r_shadow[b] <= s_data[b % 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chrom        <= INIT_CHROM;
      r_chrom_valid  <= 1'b0;
      r_chrom_update <= 1'b0;
    end else begin
      r_chrom_update <= (r_state == S_COMMIT);
      if (r_state == S_COMMIT) begin
        r_chrom       <= r_shadow;
        r_chrom_valid <= 1'b1;
      end
    end
  end

  assign chrom_out    = r_chrom;
  assign chrom_valid  = r_chrom_valid;
  assign chrom_update = r_chrom_update;
  assign busy         = (r_state != S_IDLE);
  assign byte_cnt     = r_byte_cnt;

endmodule
`default_nettype wire

// File: tb/tb_chrom_serial_loader.sv
`default_nettype none
// Randomized and directed stimulus against a frame-level reference model,
// with a scoreboard monitor that checks every chrom_update pulse.
module tb_chrom_serial_loader;

  localparam int CHROM_W = 50;
  localparam int NBYTES  = 7;
  localparam int CNT_W   = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               load_start;
  logic [7:0]         s_data;
  logic               s_valid;
  logic               s_ready;
  logic [CHROM_W-1:0] chrom_out;
  logic               chrom_valid;
  logic               chrom_update;
  logic               busy;
  logic [CNT_W-1:0]   byte_cnt;

  always #5 clk = ~clk;

  chrom_serial_loader dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .chrom_out    (chrom_out),
    .chrom_valid  (chrom_valid),
    .chrom_update (chrom_update),
    .busy         (busy),
    .byte_cnt     (byte_cnt)
  );

  int total = 0;
  int bad   = 0;

  logic [CHROM_W-1:0] exp_q[$];

  // Frame-level model: collected bytes, whether a frame is open, whether a
  // complete frame is waiting to be committed.
  logic [7:0]         m_frame[$];
  bit                 m_recv;
  bit                 m_pend;
  bit                 m_upd;
  bit                 m_valid;
  logic [CHROM_W-1:0] m_chrom;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [CHROM_W-1:0] assemble();
    logic [CHROM_W-1:0] v = '0;
    for (int k = 0; k < m_frame.size(); k++)
      for (int b = 0; b < 8; b++)
        if (8 * k + b < CHROM_W) v[8 * k + b] = m_frame[k][b];
    return v;
  endfunction

  task automatic step(input bit r, input bit ls, input bit v, input logic [7:0] d);
    @(negedge clk);
    check("chrom_out",    64'(chrom_out),    64'(m_chrom));
    check("chrom_valid",  64'(chrom_valid),  64'(m_valid));
    check("chrom_update", 64'(chrom_update), 64'(m_upd));
    check("busy",         64'(busy),         64'(m_recv || m_pend));
    check("byte_cnt",     64'(byte_cnt),     64'(m_frame.size()));
    rst = r; load_start = ls; s_valid = v; s_data = d;
    #1;
    check("s_ready", 64'(s_ready), 64'(m_recv && !ls));
    @(posedge clk);
    if (r) begin
      m_recv = 0; m_pend = 0; m_upd = 0; m_valid = 0; m_chrom = '0;
      m_frame.delete();
    end else begin
      m_upd = 0;
      if (m_pend) begin
        m_chrom = assemble();
        exp_q.push_back(m_chrom);
        m_valid = 1; m_upd = 1; m_pend = 0;
        m_recv = ls;
        m_frame.delete();
      end else if (ls) begin
        m_recv = 1;
        m_frame.delete();
      end else if (m_recv && v) begin
        m_frame.push_back(d);
        if (m_frame.size() == NBYTES) begin
          m_recv = 0; m_pend = 1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00);
  endtask

  task automatic send_frame(input logic [7:0] fr[NBYTES], input bit toggle);
    step(0, 1, 0, 8'h00);
    for (int k = 0; k < NBYTES; k++) begin
      if (toggle) step(0, 0, 0, 8'($urandom));
      step(0, 0, 1, fr[k]);
    end
  endtask

  always @(negedge clk) begin
    if (chrom_update === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard: unexpected chrom_update, chrom_out=%0h", chrom_out);
      end else begin
        logic [CHROM_W-1:0] e;
        e = exp_q.pop_front();
        check("scoreboard chrom_out", 64'(chrom_out), 64'(e));
      end
    end
  end

  logic [7:0] frame_a[NBYTES] = '{8'h5A, 8'h8B, 8'hD6, 8'h23, 8'h85, 8'hE4, 8'hFF};
  logic [7:0] frame_z[NBYTES] = '{default: 8'h00};
  logic [7:0] frame_r[NBYTES];

  initial begin
    rst = 1'b1; load_start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    m_recv = 0; m_pend = 0; m_upd = 0; m_valid = 0; m_chrom = '0;

    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    idle(2);

    send_frame(frame_a, 0);
    idle(3);
    send_frame(frame_a, 1);
    idle(3);

    for (int i = 0; i < 10; i++) step(0, 0, 1, 8'($urandom));

    step(0, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'($urandom));
    send_frame(frame_z, 0);
    idle(3);

    // Restart requested during the commit cycle.
    for (int k = 0; k < NBYTES; k++) frame_r[k] = 8'($urandom);
    send_frame(frame_r, 0);
    step(0, 1, 0, 8'h00);
    for (int k = 0; k < NBYTES; k++) step(0, 0, 1, 8'($urandom));
    idle(3);

    // Restart coincident with an offered byte.
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h11);
    step(0, 1, 1, 8'hAA);
    for (int k = 0; k < NBYTES; k++) step(0, 0, 1, 8'($urandom));
    idle(3);

    // Reset in the middle of a second frame.
    send_frame(frame_a, 0);
    idle(2);
    step(0, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'($urandom));
    step(1, 0, 0, 8'h00);
    idle(3);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0,
           ($urandom % 4) != 0, 8'($urandom));
    idle(4);

    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
